warp_scheduler: RTL and testbench
=================================

Name: warp_scheduler

Overview:
- Issue-side scheduler for one core's warps. It decides which warp owns the shared fetcher/decoder/ALU/LSU datapath and drives `warp_select`, which the warp context mux samples on negedge clk.
- It launches the warps by pulsing their resets and holding their starts, and performs round-robin context switches at instruction boundaries when the active warp stalls on memory or finishes.
- It signals core done when every valid warp has completed.

Parameters:
- NUM_WARPS, 2, number of warp contexts per core (≥2).
- WARP_ID_W, $clog2(NUM_WARPS), width of warp_select.
- SWITCH_PENALTY, 1, cycles the datapath is frozen after a select change (1..15).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  kernel launch request, level
- warp_valid  in  NUM_WARPS  warp has ≥1 thread (thread_count≠0); sampled only in IDLE→LAUNCH
- warp_stall  in  NUM_WARPS  warp waiting on LSU (any thread lsu_state REQUESTING/WAITING)
- warp_done  in  NUM_WARPS  warp executed RET (per-warp done)
- at_boundary  in  1  active warp's core_state is FETCH (safe switch point)
- warp_select  out  WARP_ID_W  index of active warp
- warp_reset  out  NUM_WARPS  per-warp reset pulse
- warp_start  out  NUM_WARPS  per-warp start level
- switch_busy  out  1  datapath freeze during switch penalty
- switch_count  out  8  saturating count of context switches this kernel
- done  out  1  kernel complete

Behaviour:
- Reset (async, reset_n=0): state=IDLE; warp_select=0, warp_reset=0, warp_start=0, switch_busy=0, switch_count=0, done=0, latched valid mask=0, penalty counter=0.
- IDLE: all outputs 0 except switch_count, which holds its last value.
  - start=1 and warp_valid≠0 → latch valid mask, go to LAUNCH.
  - start=1 with warp_valid=0 → go straight to FINISH.
- LAUNCH (1 cycle): warp_reset = valid mask; switch_count cleared; warp_select = lowest-index valid warp. Next state RUN.
- RUN: warp_start = valid mask, held through RUN/SWITCH.
  - Define remaining = valid & ~warp_done, and ready = remaining & ~warp_stall.
  - remaining=0 → FINISH.
  - Else if at_boundary=1 and the current warp is done or stalled → pick the next warp round-robin, searching from warp_select+1 with wrap-around.
    - Search ready first. If ready is empty and the current warp is done, search remaining.
    - A pick that differs from the current warp → update warp_select on this posedge, load the penalty counter with SWITCH_PENALTY, increment switch_count (saturate at 255), go to SWITCH.
    - No candidate, or pick == current → stay in RUN, no switch.
  - at_boundary=0 → never switch, even if stalled or done.
  - Done and stall both set on the current warp → treated as done.
- SWITCH: switch_busy=1 and warp_select is stable. The counter decrements each cycle; at 1 → RUN with switch_busy=0 next cycle. The warp_select update therefore precedes the first unfrozen cycle by SWITCH_PENALTY cycles, which guarantees the negedge-sampling context mux has swapped state.
- FINISH: done=1 and warp_start=0. When start=0 → IDLE. Further start activity while done=1 is ignored until start falls.
- start deasserted during LAUNCH/RUN/SWITCH: ignored; the kernel runs to completion.
- warp_valid changes after LAUNCH: ignored, because the latched mask is used.
- Indices ≥ NUM_WARPS (non-power-of-2) are never selected; round-robin wrap is modulo NUM_WARPS.
- All outputs are registered on posedge clk (no combinational input→output paths).

Decomposition:
- Package `warp_sched_pkg`:
  - `sched_state_t` enum: IDLE, LAUNCH, RUN, SWITCH, FINISH.
  - Localparam for the switch_count width (8).
- Sub-module `rr_picker`: combinational. Inputs: request mask and current index. Outputs: found flag and next index, searching from current+1 with wrap. It is instantiated twice (ready, remaining).
- The FSM, penalty counter and switch counter live in warp_scheduler.

Test Plan:
- Launch: NUM_WARPS=2, warp_valid=2'b11, start=1 → one cycle warp_reset=2'b11, then warp_start=2'b11, warp_select=0, done=0.
- Stall switch: warp 0 active, warp_stall=2'b01, at_boundary=1 → warp_select=1 next cycle, switch_busy=1 for exactly 1 cycle (SWITCH_PENALTY=1), switch_count=1. Same stimulus with at_boundary=0 → no switch.
- No-candidate hold: warp_stall=2'b11, warp 0 active at boundary → warp_select stays 0, switch_count unchanged. Then warp_done=2'b01 → switch to warp 1 even though it is stalled.
- Completion: warp_done goes 2'b01, then 2'b11 → done=1 in the cycle after remaining=0. Then start=0 → IDLE, done=0.
- Wrap/partial mask: NUM_WARPS=4, valid=4'b1010, warp 3 active, stalls, warp 1 ready → warp_select=1; warps 0 and 2 are never selected. SWITCH_PENALTY=3 → switch_busy high for 3 cycles.
- Async reset mid-SWITCH: reset_n=0 between clock edges → all outputs zero immediately, state IDLE. After reset release with start=1 → a clean LAUNCH.

Source files
------------

// File: rtl/warp_sched_pkg.sv
// Shared types and widths for the warp scheduler and its round-robin picker.
package warp_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    SWITCH,
    FINISH
  } sched_state_t;

  localparam int SWITCH_COUNT_W = 8;
  localparam int PENALTY_W      = 4;

endpackage

// File: rtl/warp_scheduler_rr_picker.sv
// Round-robin picker: first requesting index after cur, wrapping modulo NUM_WARPS.
module rr_picker #(
  parameter int NUM_WARPS = 2,
  parameter int WARP_ID_W = $clog2(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0] req,
  input  logic [WARP_ID_W-1:0] cur,
  output logic                 found,
  output logic [WARP_ID_W-1:0] next_idx
);

  logic [2*NUM_WARPS-1:0] dbl;
  logic [NUM_WARPS-1:0]   rot;
  int                     off;
  int                     sum;

  assign dbl = {req, req};

  // rot[j] holds req[(cur+1+j) mod NUM_WARPS], so the lowest set bit is the next in line
  always_comb begin
    rot   = NUM_WARPS'(dbl >> (int'(cur) + 1));
    found = 1'b0;
    off   = 0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    sum = int'(cur) + 1 + off;
    if (sum >= NUM_WARPS) sum = sum - NUM_WARPS;
    next_idx = WARP_ID_W'(sum);
  end

endmodule

// File: rtl/warp_scheduler.sv
// Issue-side warp scheduler: launches warps, switches at fetch boundaries on stall/finish,
// and freezes the datapath for SWITCH_PENALTY cycles after each select change.
module warp_scheduler
  import warp_sched_pkg::*;
#(
  parameter int NUM_WARPS      = 2,
  parameter int WARP_ID_W      = $clog2(NUM_WARPS),
  parameter int SWITCH_PENALTY = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [NUM_WARPS-1:0]      warp_valid,
  input  logic [NUM_WARPS-1:0]      warp_stall,
  input  logic [NUM_WARPS-1:0]      warp_done,
  input  logic                      at_boundary,
  output logic [WARP_ID_W-1:0]      warp_select,
  output logic [NUM_WARPS-1:0]      warp_reset,
  output logic [NUM_WARPS-1:0]      warp_start,
  output logic                      switch_busy,
  output logic [SWITCH_COUNT_W-1:0] switch_count,
  output logic                      done
);

  sched_state_t         state;
  logic [NUM_WARPS-1:0] valid_mask;
  logic [NUM_WARPS-1:0] remaining;
  logic [NUM_WARPS-1:0] ready;
  logic [PENALTY_W-1:0] penalty;
  logic                 rdy_found, rem_found;
  logic [WARP_ID_W-1:0] rdy_next, rem_next;
  logic [WARP_ID_W-1:0] pick;
  logic                 cur_done, cur_stall;
  logic                 switch_now;

  assign remaining = valid_mask & ~warp_done;
  assign ready     = remaining & ~warp_stall;
  assign cur_done  = warp_done[warp_select];
  assign cur_stall = warp_stall[warp_select];

  rr_picker #(.NUM_WARPS(NUM_WARPS), .WARP_ID_W(WARP_ID_W)) u_pick_ready (
    .req      (ready),
    .cur      (warp_select),
    .found    (rdy_found),
    .next_idx (rdy_next)
  );

  rr_picker #(.NUM_WARPS(NUM_WARPS), .WARP_ID_W(WARP_ID_W)) u_pick_remaining (
    .req      (remaining),
    .cur      (warp_select),
    .found    (rem_found),
    .next_idx (rem_next)
  );

  // A stalled-but-live warp only yields to a ready one; a finished warp yields to any live one
  always_comb begin
    pick       = warp_select;
    switch_now = 1'b0;
    if (at_boundary && (cur_done || cur_stall)) begin
      if (rdy_found) begin
        pick       = rdy_next;
        switch_now = (rdy_next != warp_select);
      end else if (cur_done && rem_found) begin
        pick       = rem_next;
        switch_now = (rem_next != warp_select);
      end
    end
  end

  function automatic logic [WARP_ID_W-1:0] lowest_valid(input logic [NUM_WARPS-1:0] mask);
    lowest_valid = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      if (mask[i]) lowest_valid = WARP_ID_W'(i);
    end
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      warp_select  <= '0;
      warp_reset   <= '0;
      warp_start   <= '0;
      switch_busy  <= 1'b0;
      switch_count <= '0;
      done         <= 1'b0;
      valid_mask   <= '0;
      penalty      <= '0;
    end else begin
      case (state)
        IDLE: begin
          warp_select <= '0;
          warp_reset  <= '0;
          warp_start  <= '0;
          switch_busy <= 1'b0;
          done        <= 1'b0;
          if (start) begin
            if (|warp_valid) begin
              valid_mask   <= warp_valid;
              warp_reset   <= warp_valid;
              warp_select  <= lowest_valid(warp_valid);
              switch_count <= '0;
              state        <= LAUNCH;
            end else begin
              done  <= 1'b1;
              state <= FINISH;
            end
          end
        end
        LAUNCH: begin
          warp_reset <= '0;
          warp_start <= valid_mask;
          state      <= RUN;
        end
        RUN: begin
          if (remaining == '0) begin
            warp_start <= '0;
            done       <= 1'b1;
            state      <= FINISH;
          end else if (switch_now) begin
            warp_select <= pick;
            penalty     <= PENALTY_W'(SWITCH_PENALTY);
            switch_busy <= 1'b1;
            if (switch_count != '1) switch_count <= switch_count + 1'b1;
            state       <= SWITCH;
          end
        end
        SWITCH: begin
          penalty <= penalty - 1'b1;
          if (penalty <= 1) begin
            switch_busy <= 1'b0;
            state       <= RUN;
          end
        end
        FINISH: begin
          if (!start) begin
            done        <= 1'b0;
            warp_select <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// Bench for warp_scheduler: directed launch/switch/finish/reset steps on a 2-warp and a
// 4-warp instance, then randomized traffic checked against a behavioural model.
module tb_warp_scheduler;

  logic       clk;
  logic       reset_n;

  logic       start2, bnd2;
  logic [1:0] valid2, stall2, done2;
  logic [0:0] sel2;
  logic [1:0] wrst2, wst2;
  logic       busy2, fin2;
  logic [7:0] cnt2;

  logic       start4, bnd4;
  logic [3:0] valid4, stall4, done4;
  logic [1:0] sel4;
  logic [3:0] wrst4, wst4;
  logic       busy4, fin4;
  logic [7:0] cnt4;

  int tests = 0;
  int fails = 0;

  warp_scheduler #(.NUM_WARPS(2), .SWITCH_PENALTY(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .warp_valid(valid2),
    .warp_stall(stall2), .warp_done(done2), .at_boundary(bnd2),
    .warp_select(sel2), .warp_reset(wrst2), .warp_start(wst2),
    .switch_busy(busy2), .switch_count(cnt2), .done(fin2)
  );

  warp_scheduler #(.NUM_WARPS(4), .SWITCH_PENALTY(3)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .warp_valid(valid4),
    .warp_stall(stall4), .warp_done(done4), .at_boundary(bnd4),
    .warp_select(sel4), .warp_reset(wrst4), .warp_start(wst4),
    .switch_busy(busy4), .switch_count(cnt4), .done(fin4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: index 0 tracks dut2, index 1 tracks dut4
  int         n_w [2] = '{2, 4};
  int         pen [2] = '{1, 3};
  logic       m_done [2];
  logic       m_launch [2];
  logic       m_run [2];
  int         m_freeze [2];
  logic [3:0] m_mask [2];
  int         m_cur [2];
  int         m_sw [2];
  logic [3:0] done_r [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_done[d] = 1'b0; m_launch[d] = 1'b0; m_run[d] = 1'b0; m_freeze[d] = 0;
      m_mask[d] = 4'd0; m_cur[d] = 0; m_sw[d] = 0; done_r[d] = 4'd0;
    end
  endtask

  task automatic model_step(input int d, input logic st, input logic [3:0] val,
                            input logic [3:0] stl, input logic [3:0] dn, input logic bnd);
    logic [3:0] lim, rem, rdy;
    int n, pick, idx;
    n   = n_w[d];
    lim = 4'((1 << n) - 1);
    if (m_done[d]) begin
      if (!st) begin m_done[d] = 1'b0; m_cur[d] = 0; end
    end else if (m_launch[d]) begin
      m_launch[d] = 1'b0;
      m_run[d]    = 1'b1;
    end else if (m_run[d]) begin
      if (m_freeze[d] > 0) begin
        m_freeze[d]--;
      end else begin
        rem = m_mask[d] & ~dn;
        rdy = rem & ~stl;
        if (rem == 4'd0) begin
          m_run[d]  = 1'b0;
          m_done[d] = 1'b1;
        end else if (bnd && (dn[m_cur[d]] || stl[m_cur[d]])) begin
          pick = -1;
          for (int k = 1; k <= n; k++) begin
            idx = (m_cur[d] + k) % n;
            if (pick < 0 && rdy[idx]) pick = idx;
          end
          if (pick < 0 && dn[m_cur[d]]) begin
            for (int k = 1; k <= n; k++) begin
              idx = (m_cur[d] + k) % n;
              if (pick < 0 && rem[idx]) pick = idx;
            end
          end
          if (pick >= 0 && pick != m_cur[d]) begin
            m_cur[d]    = pick;
            m_freeze[d] = pen[d];
            if (m_sw[d] < 255) m_sw[d]++;
          end
        end
      end
    end else if (st) begin
      if ((val & lim) != 4'd0) begin
        m_mask[d]   = val & lim;
        m_launch[d] = 1'b1;
        m_sw[d]     = 0;
        for (int i = n - 1; i >= 0; i--) if (m_mask[d][i]) m_cur[d] = i;
      end else begin
        m_done[d] = 1'b1;
      end
    end
  endtask

  task automatic check_model(input int d, input logic [31:0] sel, input logic [31:0] wr,
                             input logic [31:0] ws, input logic [31:0] bsy,
                             input logic [31:0] cnt, input logic [31:0] fin);
    string p;
    p = (d == 0) ? "rnd2" : "rnd4";
    chk({p, "_select"}, sel, 32'(m_cur[d]));
    chk({p, "_reset"},  wr,  m_launch[d] ? {28'd0, m_mask[d]} : 32'd0);
    chk({p, "_start"},  ws,  m_run[d] ? {28'd0, m_mask[d]} : 32'd0);
    chk({p, "_busy"},   bsy, (m_freeze[d] > 0) ? 32'd1 : 32'd0);
    chk({p, "_count"},  cnt, 32'(m_sw[d]));
    chk({p, "_done"},   fin, {31'd0, m_done[d]});
  endtask

  task automatic drive_rand(input int d, output logic st, output logic [3:0] val,
                            output logic [3:0] stl, output logic [3:0] dn, output logic bnd);
    logic [3:0] lim;
    logic       idle;
    lim  = 4'((1 << n_w[d]) - 1);
    idle = !m_done[d] && !m_launch[d] && !m_run[d];
    if (idle) done_r[d] = 4'd0;
    else if ($urandom_range(0, 4) == 0) done_r[d] = done_r[d] | (4'b0001 << $urandom_range(0, n_w[d] - 1));
    if (m_done[d])  st = ($urandom_range(0, 2) == 0);
    else if (idle)  st = ($urandom_range(0, 3) != 0);
    else            st = 1'($urandom_range(0, 1));
    val = ($urandom_range(0, 7) == 0) ? 4'd0 : (4'($urandom_range(0, 15)) & lim);
    stl = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & lim;
    dn  = done_r[d];
    bnd = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic       s, b;
    logic [3:0] v, sv, dv;

    reset_n = 1'b0;
    start2 = 0; bnd2 = 0; valid2 = 0; stall2 = 0; done2 = 0;
    start4 = 0; bnd4 = 0; valid4 = 0; stall4 = 0; done4 = 0;
    #12;
    chk("rst_select2", sel2, 0);  chk("rst_reset2", wrst2, 0); chk("rst_start2", wst2, 0);
    chk("rst_busy2", busy2, 0);   chk("rst_count2", cnt2, 0);  chk("rst_done2", fin2, 0);
    chk("rst_select4", sel4, 0);  chk("rst_done4", fin4, 0);
    reset_n = 1'b1;

    // 2-warp launch
    valid2 = 2'b11; start2 = 1'b1;
    tick();
    chk("launch_reset", wrst2, 2'b11); chk("launch_select", sel2, 0);
    chk("launch_start", wst2, 0);      chk("launch_done", fin2, 0);
    tick();
    chk("run_start", wst2, 2'b11); chk("run_reset", wrst2, 0); chk("run_select", sel2, 0);

    // stall without boundary: no switch
    stall2 = 2'b01; bnd2 = 1'b0;
    tick();
    chk("noboundary_select", sel2, 0); chk("noboundary_busy", busy2, 0); chk("noboundary_count", cnt2, 0);

    // stall at boundary: switch to warp 1
    bnd2 = 1'b1;
    tick();
    chk("stall_select", sel2, 1); chk("stall_busy", busy2, 1); chk("stall_count", cnt2, 1);
    stall2 = 2'b00; bnd2 = 1'b0;
    tick();
    chk("penalty1_busy", busy2, 0); chk("penalty1_select", sel2, 1);

    // both stalled: hold
    stall2 = 2'b11; bnd2 = 1'b1;
    tick();
    chk("hold_select", sel2, 1); chk("hold_count", cnt2, 1); chk("hold_busy", busy2, 0);

    // current done: switch to the stalled survivor
    done2 = 2'b10;
    tick();
    chk("done_sw_select", sel2, 0); chk("done_sw_count", cnt2, 2); chk("done_sw_busy", busy2, 1);
    stall2 = 2'b00; bnd2 = 1'b0;
    tick();
    chk("done_sw_unfreeze", busy2, 0);

    // completion
    done2 = 2'b11;
    tick();
    chk("finish_done", fin2, 1); chk("finish_start", wst2, 0);
    tick();
    chk("finish_hold", fin2, 1);
    start2 = 1'b0;
    tick();
    chk("idle_done", fin2, 0); chk("idle_select", sel2, 0); chk("idle_count_hold", cnt2, 2);

    // start with no valid warps: straight to finish
    done2 = 2'b00; valid2 = 2'b00; start2 = 1'b1;
    tick();
    chk("empty_done", fin2, 1); chk("empty_reset", wrst2, 0);
    start2 = 1'b0;
    tick();
    chk("empty_idle", fin2, 0);

    // 4-warp partial mask with wrap
    valid4 = 4'b1010; start4 = 1'b1;
    tick();
    chk("w4_launch_reset", wrst4, 4'b1010); chk("w4_launch_select", sel4, 1);
    tick();
    chk("w4_run_start", wst4, 4'b1010);
    stall4 = 4'b0010; bnd4 = 1'b1;
    tick();
    chk("w4_sw_select", sel4, 3); chk("w4_sw_busy0", busy4, 1); chk("w4_sw_count", cnt4, 1);
    stall4 = 4'b0000; bnd4 = 1'b0;
    tick();
    chk("w4_sw_busy1", busy4, 1);
    tick();
    chk("w4_sw_busy2", busy4, 1);
    tick();
    chk("w4_sw_busy3", busy4, 0); chk("w4_sw_select_hold", sel4, 3);
    stall4 = 4'b1000; bnd4 = 1'b1;
    tick();
    chk("w4_wrap_select", sel4, 1); chk("w4_wrap_count", cnt4, 2); chk("w4_wrap_busy", busy4, 1);

    // async reset in the middle of a switch penalty
    stall4 = 4'b0000; bnd4 = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_select", sel4, 0); chk("async_busy", busy4, 0); chk("async_count", cnt4, 0);
    chk("async_start", wst4, 0);  chk("async_reset", wrst4, 0); chk("async_done", fin4, 0);
    reset_n = 1'b1;
    tick();
    chk("relaunch_reset", wrst4, 4'b1010); chk("relaunch_select", sel4, 1); chk("relaunch_count", cnt4, 0);
    tick();
    chk("relaunch_start", wst4, 4'b1010);

    // randomized traffic against the model
    start2 = 0; valid2 = 0; stall2 = 0; done2 = 0; bnd2 = 0;
    start4 = 0; valid4 = 0; stall4 = 0; done4 = 0; bnd4 = 0;
    reset_n = 1'b0;
    model_reset();
    #2;
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      drive_rand(0, s, v, sv, dv, b);
      start2 = s; valid2 = v[1:0]; stall2 = sv[1:0]; done2 = dv[1:0]; bnd2 = b;
      drive_rand(1, s, v, sv, dv, b);
      start4 = s; valid4 = v; stall4 = sv; done4 = dv; bnd4 = b;
      model_step(0, start2, {2'b00, valid2}, {2'b00, stall2}, {2'b00, done2}, bnd2);
      model_step(1, start4, valid4, stall4, done4, bnd4);
      tick();
      check_model(0, 32'(sel2), 32'(wrst2), 32'(wst2), 32'(busy2), 32'(cnt2), 32'(fin2));
      check_model(1, 32'(sel4), 32'(wrst4), 32'(wst4), 32'(busy4), 32'(cnt4), 32'(fin4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
